// File: rtl/shiftreg_pkg.sv
// Shared definitions for the shift_register_hs handshake shift register:
// operation encodings and controller state enum.
package shiftreg_pkg;

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_SHL  = 3'b001;
   localparam logic [2:0] OP_SHR  = 3'b010;
   localparam logic [2:0] OP_SAR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

   // Ops 11x carry no data effect and complete immediately.
   function automatic logic is_nop(input logic [2:0] op);
      return (op[2:1] == 2'b11);
   endfunction

endpackage

// File: rtl/shift_unit.sv
// Combinational single-bit step of a shift/rotate op on {data, carry}.
// LOAD and NOP encodings pass data and carry through unchanged.
module shift_unit
   import shiftreg_pkg::*;
#(
   parameter int Width = 32
) (
   input  logic [2:0]       op_i,
   input  logic [Width-1:0] data_i,
   input  logic             carry_i,
   output logic [Width-1:0] data_o,
   output logic             carry_o
);

   // One-bit step selected by the operation code.
   always_comb begin
      data_o  = data_i;
      carry_o = carry_i;
      case (op_i)
         OP_SHL: {carry_o, data_o} = {data_i, 1'b0};
         OP_SHR: {data_o, carry_o} = {1'b0, data_i};
         OP_SAR: {data_o, carry_o} = {data_i[Width-1], data_i};
         OP_ROL: begin
            data_o  = {data_i[Width-2:0], data_i[Width-1]};
            carry_o = data_i[Width-1];
         end
         OP_ROR: begin
            data_o  = {data_i[0], data_i[Width-1:1]};
            carry_o = data_i[0];
         end
         default: begin
            data_o  = data_i;
            carry_o = carry_i;
         end
      endcase
   end

endmodule

// File: rtl/shift_register_hs.sv
// Multi-mode shift register behind a 4-phase req/fin handshake.
// SHIFTREG_BARREL_EN selects a single-cycle barrel datapath instead of 1 bit/cycle.
module shift_register_hs
   import shiftreg_pkg::*;
#(
   parameter int Width = 32,
   parameter int AMT_W = $clog2(Width)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amt,
   input  logic [Width-1:0] in,
   output logic             fin,
   output logic             busy,
   output logic [Width-1:0] out,
   output logic             carry
);

   state_e           state_q, state_d;
   logic [Width-1:0] out_q, out_d;
   logic             carry_q, carry_d;
   logic             fin_q, fin_d;
   logic             busy_q, busy_d;
   logic             armed_q, armed_d;
   logic [2:0]       op_q, op_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [Width-1:0] res_data_s;
   logic             res_carry_s;

`ifdef SHIFTREG_BARREL_EN
   logic [2*Width-1:0] bar_ext_s;
   int                 bar_rot_s;

   // Full multi-bit result from the latched amount; an oversize amount drains to fill.
   always_comb begin
      bar_ext_s   = '0;
      bar_rot_s   = int'(cnt_q) % Width;
      res_data_s  = out_q;
      res_carry_s = carry_q;
      if (cnt_q != '0) begin
         case (op_q)
            OP_SHL: begin
               bar_ext_s   = {{Width{1'b0}}, out_q} << cnt_q;
               res_data_s  = bar_ext_s[Width-1:0];
               res_carry_s = bar_ext_s[Width];
            end
            OP_SHR: begin
               bar_ext_s   = {out_q, {Width{1'b0}}} >> cnt_q;
               res_data_s  = bar_ext_s[2*Width-1:Width];
               res_carry_s = bar_ext_s[Width-1];
            end
            OP_SAR: begin
               bar_ext_s   = $signed({out_q, {Width{1'b0}}}) >>> cnt_q;
               res_data_s  = bar_ext_s[2*Width-1:Width];
               res_carry_s = bar_ext_s[Width-1];
            end
            OP_ROL: begin
               bar_ext_s   = {out_q, out_q} << bar_rot_s;
               res_data_s  = bar_ext_s[2*Width-1:Width];
               res_carry_s = bar_ext_s[Width];
            end
            OP_ROR: begin
               bar_ext_s   = {out_q, out_q} >> bar_rot_s;
               res_data_s  = bar_ext_s[Width-1:0];
               res_carry_s = bar_ext_s[Width-1];
            end
            default: begin
               res_data_s  = out_q;
               res_carry_s = carry_q;
            end
         endcase
      end else begin
         res_data_s  = out_q;
         res_carry_s = carry_q;
      end
   end
`else
   shift_unit #(.Width(Width)) u_step (
      .op_i    (op_q),
      .data_i  (out_q),
      .carry_i (carry_q),
      .data_o  (res_data_s),
      .carry_o (res_carry_s)
   );
`endif

   // Handshake controller and datapath next-state.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      carry_d = carry_q;
      fin_d   = fin_q;
      busy_d  = busy_q;
      armed_d = armed_q | ~req;
      op_d    = op_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req && armed_q) begin
               state_d = BUSY;
               busy_d  = 1'b1;
               armed_d = 1'b0;
               op_d    = op;
               if (op == OP_LOAD) begin
                  out_d   = in;
                  carry_d = 1'b0;
                  cnt_d   = '0;
               end else if (is_nop(op)) begin
                  cnt_d = '0;
               end else begin
                  cnt_d = amt;
               end
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
`ifdef SHIFTREG_BARREL_EN
            out_d   = res_data_s;
            carry_d = res_carry_s;
            state_d = DONE;
            fin_d   = 1'b1;
`else
            if (cnt_q != '0) begin
               out_d   = res_data_s;
               carry_d = res_carry_s;
               cnt_d   = cnt_q - {{(AMT_W-1){1'b0}}, 1'b1};
            end else begin
               state_d = DONE;
               fin_d   = 1'b1;
            end
`endif
         end
         DONE: begin
            if (!req) begin
               fin_d   = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            fin_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers; reset wins over any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         out_q   <= '0;
         carry_q <= 1'b0;
         fin_q   <= 1'b0;
         busy_q  <= 1'b0;
         armed_q <= 1'b0;
         op_q    <= OP_LOAD;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         carry_q <= carry_d;
         fin_q   <= fin_d;
         busy_q  <= busy_d;
         armed_q <= armed_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out   = out_q;
   assign carry = carry_q;
   assign fin   = fin_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_shift_register_hs.sv
// Directed bench for shift_register_hs: a Width=32 and a Width=24 instance share
// the handshake and see identical op sequences; SHIFTREG_BARREL_EN changes expected latency.
module tb_shift_register_hs;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [2:0]  op;
   logic [4:0]  amt;
   logic [31:0] in_v;
   logic        fin32, busy32, carry32;
   logic [31:0] out32;
   logic        fin24, busy24, carry24;
   logic [23:0] out24;

   int chk_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   shift_register_hs #(.Width(32)) dut32 (
      .clk(clk), .rst(rst), .req(req), .op(op), .amt(amt), .in(in_v),
      .fin(fin32), .busy(busy32), .out(out32), .carry(carry32)
   );

   shift_register_hs #(.Width(24)) dut24 (
      .clk(clk), .rst(rst), .req(req), .op(op), .amt(amt), .in(in_v[23:0]),
      .fin(fin24), .busy(busy24), .out(out24), .carry(carry24)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input logic [2:0] o, input logic [4:0] a);
`ifdef SHIFTREG_BARREL_EN
      return 1;
`else
      if (o == 3'b000 || o[2:1] == 2'b11) return 1;
      return int'(a) + 1;
`endif
   endfunction

   // Starts at a negedge with the DUT idle and armed; returns idle and armed.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [4:0] a,
                         input logic [31:0] d, input bit drop_early);
      int n;
      req  = 1'b1;
      op   = o;
      amt  = a;
      in_v = d;
      @(negedge clk);
      check_val({tag, ".busy"}, {31'd0, busy32}, 32'd1);
      check_val({tag, ".busy24"}, {31'd0, busy24}, 32'd1);
      op   = 3'($urandom);
      amt  = 5'($urandom);
      in_v = $urandom;
      if (drop_early) req = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fin32 && n < 80);
      check_val({tag, ".lat"}, n, exp_lat(o, a));
      if (!drop_early) req = 1'b0;
      @(negedge clk);
      check_val({tag, ".fin_lo"}, {31'd0, fin32}, 32'd0);
      check_val({tag, ".busy_lo"}, {31'd0, busy32}, 32'd0);
   endtask

   task automatic chk_res(input string tag, input logic [31:0] e32, input logic ec32,
                          input logic [23:0] e24, input logic ec24);
      check_val({tag, ".out32"}, out32, e32);
      check_val({tag, ".c32"}, {31'd0, carry32}, {31'd0, ec32});
      check_val({tag, ".out24"}, {8'd0, out24}, {8'd0, e24});
      check_val({tag, ".c24"}, {31'd0, carry24}, {31'd0, ec24});
   endtask

   initial begin
      rst  = 1'b1;
      req  = 1'b1;
      op   = 3'b000;
      amt  = 5'd0;
      in_v = 32'h1234_5678;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_val("rst.busy", {31'd0, busy32}, 32'd0);
      check_val("rst.fin", {31'd0, fin32}, 32'd0);
      check_val("rst.busy24", {31'd0, busy24}, 32'd0);
      chk_res("rst", 32'h0, 1'b0, 24'h0, 1'b0);
      req = 1'b0;
      @(negedge clk);

      run_op("load", 3'b000, 5'd0, 32'hA5A5_0001, 1'b0);
      chk_res("load", 32'hA5A5_0001, 1'b0, 24'hA5_0001, 1'b0);

      run_op("ld1", 3'b000, 5'd0, 32'h8000_0001, 1'b0);
      run_op("shl1", 3'b001, 5'd1, 32'h0, 1'b0);
      chk_res("shl1", 32'h0000_0002, 1'b1, 24'h00_0002, 1'b0);
      run_op("ror0", 3'b101, 5'd0, 32'h0, 1'b0);
      chk_res("ror0", 32'h0000_0002, 1'b1, 24'h00_0002, 1'b0);

      run_op("ld2", 3'b000, 5'd0, 32'h8000_0000, 1'b0);
      run_op("sar4", 3'b011, 5'd4, 32'h0, 1'b0);
      chk_res("sar4", 32'hF800_0000, 1'b0, 24'h0, 1'b0);
      run_op("ld3", 3'b000, 5'd0, 32'h8000_0000, 1'b0);
      run_op("shr4", 3'b010, 5'd4, 32'h0, 1'b0);
      chk_res("shr4", 32'h0800_0000, 1'b0, 24'h0, 1'b0);

      run_op("ld4", 3'b000, 5'd0, 32'h0000_00F1, 1'b0);
      run_op("ror4", 3'b101, 5'd4, 32'h0, 1'b0);
      chk_res("ror4", 32'h1000_000F, 1'b0, 24'h10_000F, 1'b0);
      run_op("rol0", 3'b100, 5'd0, 32'h0, 1'b0);
      chk_res("rol0", 32'h1000_000F, 1'b0, 24'h10_000F, 1'b0);

      run_op("ld5", 3'b000, 5'd0, 32'h6000_0003, 1'b0);
      run_op("early", 3'b001, 5'd3, 32'h0, 1'b1);
      chk_res("early", 32'h0000_0018, 1'b1, 24'h00_0018, 1'b0);

      run_op("ld6", 3'b000, 5'd0, 32'h00FF_FFFF, 1'b0);
      run_op("shr31", 3'b010, 5'd31, 32'h0, 1'b0);
      chk_res("shr31", 32'h0, 1'b0, 24'h0, 1'b0);

      run_op("ld7", 3'b000, 5'd0, 32'h0080_0001, 1'b0);
      run_op("rol25", 3'b100, 5'd25, 32'h0, 1'b0);
      chk_res("rol25", 32'h0201_0000, 1'b0, 24'h00_0003, 1'b1);

      run_op("ld8", 3'b000, 5'd0, 32'h0080_0000, 1'b0);
      run_op("sar30", 3'b011, 5'd30, 32'h0, 1'b0);
      chk_res("sar30", 32'h0, 1'b0, 24'hFF_FFFF, 1'b1);

      run_op("ld9", 3'b000, 5'd0, 32'h0080_0001, 1'b0);
      run_op("shl24", 3'b001, 5'd24, 32'h0, 1'b0);
      chk_res("shl24", 32'h0100_0000, 1'b0, 24'h0, 1'b1);
      run_op("nop", 3'b111, 5'd5, 32'hDEAD_BEEF, 1'b0);
      chk_res("nop", 32'h0100_0000, 1'b0, 24'h0, 1'b1);

      // Reset in the middle of a long shift, req held high throughout.
      run_op("ld10", 3'b000, 5'd0, 32'hFFFF_FFFF, 1'b0);
      req = 1'b1;
      op  = 3'b001;
      amt = 5'd20;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("mrst.fin", {31'd0, fin32}, 32'd0);
      check_val("mrst.busy", {31'd0, busy32}, 32'd0);
      chk_res("mrst", 32'h0, 1'b0, 24'h0, 1'b0);
      repeat (6) @(negedge clk);
      check_val("nocap.busy", {31'd0, busy32}, 32'd0);
      check_val("nocap.out", out32, 32'h0);
      req = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
